// File: rtl/ddrphy_wr_path.sv
// ddrphy_wr_path: DFI write datapath with programmable latency delay line and DQS preamble/postamble/gap FSM.
module ddrphy_wr_path #(
  parameter int NUM_LANES  = 8,
  parameter int LANE_WIDTH = 8,
  parameter int WRLAT_W    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WRLAT_W-1:0]                cfg_wrlat,
  input  logic                              dfi_wrdata_en,
  input  logic [2*NUM_LANES*LANE_WIDTH-1:0] dfi_wrdata,
  input  logic [2*NUM_LANES-1:0]            dfi_wrdata_mask,
  output logic                              dq_oe,
  output logic [NUM_LANES*LANE_WIDTH-1:0]   dq_rise,
  output logic [NUM_LANES*LANE_WIDTH-1:0]   dq_fall,
  output logic [NUM_LANES-1:0]              dm_rise,
  output logic [NUM_LANES-1:0]              dm_fall,
  output logic [NUM_LANES-1:0]              dqs_oe,
  output logic [NUM_LANES-1:0]              dqs_toggle,
  output logic                              cfg_busy,
  output logic [CNT_W-1:0]                  burst_cnt
);
  localparam int DW    = NUM_LANES*LANE_WIDTH;
  localparam int DEPTH = 2**WRLAT_W + 1;
  localparam int IW    = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, PRE, DATA, GAP, POST} state_t;
  state_t                 state_q, state_d;
  logic [DEPTH-1:0]       en_q;
  logic [2*DW-1:0]        dat_q [DEPTH];
  logic [2*NUM_LANES-1:0] msk_q [DEPTH];
  logic [WRLAT_W-1:0]     lact_q;
  logic                   dq_oe_q;
  logic [DW-1:0]          dq_rise_q, dq_fall_q;
  logic [NUM_LANES-1:0]   dm_rise_q, dm_fall_q;
  logic [CNT_W-1:0]       burst_cnt_q;
  logic [IW-1:0]          la_idx, de_idx;
  logic                   la, de;
  logic [2*DW-1:0]        dat_tap;
  logic [2*NUM_LANES-1:0] msk_tap;
  // en_q[k] holds the enable sampled k+1 edges ago, so depth L+1 is index L
  assign la_idx  = IW'(lact_q);
  assign de_idx  = la_idx + IW'(1);
  assign la      = en_q[la_idx];
  assign de      = en_q[de_idx];
  assign dat_tap = dat_q[de_idx];
  assign msk_tap = msk_q[de_idx];
  assign cfg_busy = (state_q != IDLE) || (|en_q) || dfi_wrdata_en;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = la ? PRE : IDLE;
      PRE:     state_d = DATA;
      DATA:    state_d = de ? DATA : la ? GAP : POST;
      GAP:     state_d = DATA;
      POST:    state_d = la ? PRE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      en_q        <= '0;
      lact_q      <= cfg_wrlat;
      dq_oe_q     <= 1'b0;
      dq_rise_q   <= '0;
      dq_fall_q   <= '0;
      dm_rise_q   <= '0;
      dm_fall_q   <= '0;
      burst_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        msk_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      en_q     <= {en_q[DEPTH-2:0], dfi_wrdata_en};
      dat_q[0] <= dfi_wrdata;
      msk_q[0] <= dfi_wrdata_mask;
      for (int i = 1; i < DEPTH; i++) begin
        dat_q[i] <= dat_q[i-1];
        msk_q[i] <= msk_q[i-1];
      end
      dq_oe_q   <= de;
      dq_rise_q <= de ? dat_tap[DW-1:0] : '0;
      dq_fall_q <= de ? dat_tap[2*DW-1:DW] : '0;
      dm_rise_q <= de ? msk_tap[NUM_LANES-1:0] : '0;
      dm_fall_q <= de ? msk_tap[2*NUM_LANES-1:NUM_LANES] : '0;
      if (!cfg_busy)
        lact_q <= cfg_wrlat;
      if (state_d == PRE && burst_cnt_q != '1)
        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
    end
  end
  assign dq_oe      = dq_oe_q;
  assign dq_rise    = dq_rise_q;
  assign dq_fall    = dq_fall_q;
  assign dm_rise    = dm_rise_q;
  assign dm_fall    = dm_fall_q;
  assign dqs_oe     = {NUM_LANES{state_q != IDLE}};
  assign dqs_toggle = {NUM_LANES{state_q == DATA}};
  assign burst_cnt  = burst_cnt_q;
endmodule

// File: tb/tb_ddrphy_wr_path.sv
// tb_ddrphy_wr_path: directed table-driven checks of ddrphy_wr_path latency, FSM, gating and counter.
module tb_ddrphy_wr_path;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   cfg_wrlat = '0;
  logic         en = 1'b0;
  logic [127:0] wd = '0;
  logic [15:0]  wm = '0;
  logic         dq_oe, dq_oe4, busy, busy4;
  logic [63:0]  dq_rise, dq_fall, dq_rise4, dq_fall4;
  logic [7:0]   dm_rise, dm_fall, dqs_oe, dqs_toggle, dm_rise4, dm_fall4, dqs_oe4, dqs_toggle4;
  logic [15:0]  burst_cnt;
  logic [3:0]   burst_cnt4;
  int checks = 0, failures = 0, t = 0;
  always #5 clk = ~clk;
  ddrphy_wr_path dut (
    .clk(clk), .rst(rst), .cfg_wrlat(cfg_wrlat), .dfi_wrdata_en(en), .dfi_wrdata(wd),
    .dfi_wrdata_mask(wm), .dq_oe(dq_oe), .dq_rise(dq_rise), .dq_fall(dq_fall),
    .dm_rise(dm_rise), .dm_fall(dm_fall), .dqs_oe(dqs_oe), .dqs_toggle(dqs_toggle),
    .cfg_busy(busy), .burst_cnt(burst_cnt)
  );
  ddrphy_wr_path #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_wrlat(cfg_wrlat), .dfi_wrdata_en(en), .dfi_wrdata(wd),
    .dfi_wrdata_mask(wm), .dq_oe(dq_oe4), .dq_rise(dq_rise4), .dq_fall(dq_fall4),
    .dm_rise(dm_rise4), .dm_fall(dm_fall4), .dqs_oe(dqs_oe4), .dqs_toggle(dqs_toggle4),
    .cfg_busy(busy4), .burst_cnt(burst_cnt4)
  );
  typedef struct {
    logic en; logic [127:0] d; logic [15:0] m;
    logic oe; logic dqs; logic tog; logic [127:0] q; logic [15:0] qm; logic [15:0] cnt; logic busy;
  } vec_t;
  localparam logic [127:0] DA = {64'hA1A2A3A4A5A6A7A8, 64'h1122334455667788};
  localparam logic [127:0] DB = {64'hB1B2B3B4B5B6B7B8, 64'h99AABBCCDDEEFF00};
  localparam logic [15:0]  MA = 16'h5A3C;
  localparam logic [15:0]  MB = 16'hC3F0;
  vec_t tbl [6];
  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", n, t, got, exp);
    end
  endtask
  task automatic cyc(input logic e, input logic [127:0] d, input logic [15:0] m);
    en = e; wd = d; wm = m;
    @(posedge clk);
    #1;
    t++;
  endtask
  task automatic idle();
    cyc(1'b0, '1, '1);
  endtask
  task automatic do_reset(input logic [3:0] l);
    rst = 1'b1; cfg_wrlat = l;
    idle();
    rst = 1'b0; t = -1;
  endtask
  task automatic run_table();
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].en, tbl[i].d, tbl[i].m);
      chk("tbl_dq_oe", dq_oe, tbl[i].oe);
      chk("tbl_dqs_oe", dqs_oe, {8{tbl[i].dqs}});
      chk("tbl_toggle", dqs_toggle, {8{tbl[i].tog}});
      chk("tbl_dq", {dq_fall, dq_rise}, tbl[i].q);
      chk("tbl_dm", {dm_fall, dm_rise}, tbl[i].qm);
      chk("tbl_cnt", burst_cnt, tbl[i].cnt);
      chk("tbl_busy", busy, tbl[i].busy);
    end
  endtask
  initial begin
    int oe_n, dqs_n, e7, e8, ee;
    int x7[4], x8[4], xc[4], xd[4];
    tbl[0] = '{1'b1, DA, MA, 1'b0, 1'b0, 1'b0, '0, '0, 16'd0, 1'b1};
    tbl[1] = '{1'b1, DB, MB, 1'b0, 1'b1, 1'b0, '0, '0, 16'd1, 1'b1};
    tbl[2] = '{1'b0, '1, '1, 1'b1, 1'b1, 1'b1, DA, MA, 16'd1, 1'b1};
    tbl[3] = '{1'b0, '1, '1, 1'b1, 1'b1, 1'b1, DB, MB, 16'd1, 1'b1};
    tbl[4] = '{1'b0, '1, '1, 1'b0, 1'b1, 1'b0, '0, '0, 16'd1, 1'b1};
    tbl[5] = '{1'b0, '1, '1, 1'b0, 1'b0, 1'b0, '0, '0, 16'd1, 1'b1};
    x7 = '{3, 2, 2, 2}; x8 = '{3, 3, 2, 0}; xc = '{1, 1, 2, 2}; xd = '{6, 7, 8, 8};
    do_reset(4'd0);
    chk("rst_dq_oe", dq_oe, 1'b0);
    chk("rst_dqs_oe", dqs_oe, 8'h00);
    chk("rst_dq", {dq_fall, dq_rise, dm_fall, dm_rise}, '0);
    chk("rst_cnt", burst_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    run_table();
    do_reset(4'd5);
    cyc(1'b1, DA, 16'h00FF);
    chk("l5_oe0", dq_oe, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      idle();
      chk("l5_oe", dq_oe, k == 7);
      chk("l5_dq", {dq_fall, dq_rise}, (k == 7) ? DA : 128'h0);
      chk("l5_dm", {dm_fall, dm_rise}, (k == 7) ? 16'h00FF : 16'h0000);
      chk("l5_dqs", dqs_oe, (k >= 6 && k <= 8) ? 8'hFF : 8'h00);
      chk("l5_tog", dqs_toggle, (k == 7) ? 8'hFF : 8'h00);
    end
    for (int g = 0; g < 4; g++) begin
      do_reset(4'd3);
      oe_n = 0; dqs_n = 0; e7 = 0; e8 = 0;
      for (int e = 0; e < 20; e++) begin
        cyc((e < 2) || (e >= 2 + g && e < 4 + g), DB, MB);
        oe_n += int'(dq_oe);
        dqs_n += int'(dqs_oe[0]);
        if (e == 7) e7 = {dqs_oe[0], dqs_toggle[0]};
        if (e == 8) e8 = {dqs_oe[0], dqs_toggle[0]};
      end
      chk("gap_state7", e7, x7[g]);
      chk("gap_state8", e8, x8[g]);
      chk("gap_cnt", burst_cnt, xc[g]);
      chk("gap_oe_cycles", oe_n, 4);
      chk("gap_dqs_cycles", dqs_n, xd[g]);
    end
    do_reset(4'd2);
    cyc(1'b1, DA, MA);
    cfg_wrlat = 4'd9;
    cyc(1'b1, DB, MB);
    for (int e = 2; e <= 6; e++) begin
      idle();
      chk("relat_old_oe", dq_oe, e == 4 || e == 5);
    end
    while (busy && t < 60) idle();
    chk("relat_busy_drop", t, 18);
    idle();
    cyc(1'b1, DA, MA);
    for (int k = 1; k <= 12; k++) begin
      idle();
      chk("relat_new_oe", dq_oe, k == 11);
    end
    do_reset(4'd0);
    cyc(1'b1, DA, MA);
    cyc(1'b1, DB, MB);
    idle();
    chk("mid_data_oe", dq_oe, 1'b1);
    do_reset(4'd0);
    chk("mid_rst_oe", dq_oe, 1'b0);
    chk("mid_rst_dqs", dqs_oe, 8'h00);
    chk("mid_rst_cnt", burst_cnt, 16'd0);
    for (int k = 0; k < 20; k++) idle();
    do_reset(4'd0);
    run_table();
    do_reset(4'd0);
    for (int b = 0; b < 17; b++) begin
      cyc(1'b1, DA, MA);
      for (int k = 0; k < 5; k++) idle();
      if (b == 14) chk("sat_cnt4_at15", burst_cnt4, 4'd15);
    end
    ee = int'(burst_cnt4);
    chk("sat_cnt4", ee, 15);
    chk("sat_cnt16", burst_cnt, 16'd17);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
